// File: rtl/ddi_phase_sequencer_if.sv
// Signal bundle between the DDI phase sequencer and its timing/request environment.
// master = sequencer side (drives phase state, acks, status); slave = environment side.
interface ddi_phase_sequencer_if;
    logic       timing_done;
    logic       east_sync_req;
    logic       west_sync_req;
    logic       maint_req;
    logic [3:0] current_state;
    logic       east_sync_ack;
    logic       west_sync_ack;
    logic       east_pending;
    logic       west_pending;
    logic       maint_active;

    modport master (
        input  timing_done,
        input  east_sync_req,
        input  west_sync_req,
        input  maint_req,
        output current_state,
        output east_sync_ack,
        output west_sync_ack,
        output east_pending,
        output west_pending,
        output maint_active
    );

    modport slave (
        output timing_done,
        output east_sync_req,
        output west_sync_req,
        output maint_req,
        input  current_state,
        input  east_sync_ack,
        input  west_sync_ack,
        input  east_pending,
        input  west_pending,
        input  maint_active
    );
endinterface

// File: rtl/ddi_phase_sequencer.sv
// DDI phase scheduler: normal two-phase cycle, E/W sync platoons, maintenance; optional SYNC_FAIRNESS_EN caps sync runs.
// Latency: state registered one cycle after a qualified timing_done; acks/pendings registered alongside.
// Backpressure: none; requests are latched until served, timing_done is ignored in the blank cycle.
module ddi_phase_sequencer #(
    parameter bit SYNC_RR_INIT = 1'b0,
    parameter int MAX_SYNC_RUN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ddi_phase_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        ALL_RED          = 4'd0,
        PHASE_1_GREEN    = 4'd1,
        PHASE_1_YELLOW   = 4'd2,
        PHASE_2_GREEN    = 4'd3,
        PHASE_2_YELLOW   = 4'd4,
        EASTBOUND_GREEN  = 4'd5,
        EASTBOUND_YELLOW = 4'd6,
        WESTBOUND_GREEN  = 4'd7,
        WESTBOUND_YELLOW = 4'd8,
        MAINTENANCE      = 4'd9
    } state_t;

    state_t state_q, state_d;

    logic blank_q;
    logic rr_ptr_q;
    logic next_p2_q;
    logic east_pend_q, west_pend_q;
    logic east_ack_q, west_ack_q;

    logic done_qual;
    logic grant_east;
    logic sync_ok;
    logic state_chg;
    logic enter_east, enter_west, enter_normal;

    assign done_qual  = bus.timing_done & ~blank_q;
    // Both pending: rr_ptr arbitrates; single pending always wins.
    assign grant_east = east_pend_q & (~west_pend_q | ~rr_ptr_q);

`ifdef SYNC_FAIRNESS_EN
    localparam int RUN_W = (MAX_SYNC_RUN < 1) ? 1 : $clog2(MAX_SYNC_RUN + 1);
    logic [RUN_W-1:0] sync_run_q;

    assign sync_ok = (sync_run_q != RUN_W'(MAX_SYNC_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_run_q <= '0;
        end else if (enter_normal) begin
            sync_run_q <= '0;
        end else if ((enter_east | enter_west) && sync_ok) begin
            sync_run_q <= sync_run_q + RUN_W'(1);
        end
    end
`else
    localparam int unused_max_sync_run = MAX_SYNC_RUN;
    assign sync_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALL_RED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALL_RED: begin
                if (done_qual) begin
                    if (bus.maint_req) begin
                        state_d = MAINTENANCE;
                    end else if ((east_pend_q | west_pend_q) && sync_ok) begin
                        state_d = grant_east ? EASTBOUND_GREEN : WESTBOUND_GREEN;
                    end else begin
                        state_d = next_p2_q ? PHASE_2_GREEN : PHASE_1_GREEN;
                    end
                end
            end
            PHASE_1_GREEN:    if (done_qual) state_d = PHASE_1_YELLOW;
            PHASE_1_YELLOW:   if (done_qual) state_d = ALL_RED;
            PHASE_2_GREEN:    if (done_qual) state_d = PHASE_2_YELLOW;
            PHASE_2_YELLOW:   if (done_qual) state_d = ALL_RED;
            EASTBOUND_GREEN:  if (done_qual) state_d = EASTBOUND_YELLOW;
            EASTBOUND_YELLOW: if (done_qual) state_d = ALL_RED;
            WESTBOUND_GREEN:  if (done_qual) state_d = WESTBOUND_YELLOW;
            WESTBOUND_YELLOW: if (done_qual) state_d = ALL_RED;
            // Maintenance ignores the timer and leaves as soon as the request drops.
            MAINTENANCE:      if (!bus.maint_req) state_d = ALL_RED;
            default:          state_d = ALL_RED;
        endcase
    end

    assign state_chg    = (state_d != state_q);
    assign enter_east   = state_chg && (state_d == EASTBOUND_GREEN);
    assign enter_west   = state_chg && (state_d == WESTBOUND_GREEN);
    assign enter_normal = state_chg && ((state_d == PHASE_1_GREEN) || (state_d == PHASE_2_GREEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q     <= 1'b1;
            rr_ptr_q    <= SYNC_RR_INIT;
            next_p2_q   <= 1'b0;
            east_pend_q <= 1'b0;
            west_pend_q <= 1'b0;
            east_ack_q  <= 1'b0;
            west_ack_q  <= 1'b0;
        end else begin
            blank_q     <= state_chg;
            east_ack_q  <= enter_east;
            west_ack_q  <= enter_west;
            // A request arriving with the grant re-arms the latch for a later phase.
            east_pend_q <= bus.east_sync_req | (east_pend_q & ~enter_east);
            west_pend_q <= bus.west_sync_req | (west_pend_q & ~enter_west);
            if (enter_east) begin
                rr_ptr_q <= 1'b1;
            end else if (enter_west) begin
                rr_ptr_q <= 1'b0;
            end
            if (enter_normal) begin
                next_p2_q <= ~next_p2_q;
            end
        end
    end

    assign bus.current_state = state_q;
    assign bus.east_sync_ack = east_ack_q;
    assign bus.west_sync_ack = west_ack_q;
    assign bus.east_pending  = east_pend_q;
    assign bus.west_pending  = west_pend_q;
    assign bus.maint_active  = (state_q == MAINTENANCE);

endmodule

// File: tb/tb_ddi_phase_sequencer.sv
// Bench for ddi_phase_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_ddi_phase_sequencer;

    localparam int MAX_RUN = 2;
`ifdef SYNC_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    localparam int AR = 0, P1G = 1, P1Y = 2, P2G = 3, P2Y = 4;
    localparam int EBG = 5, EBY = 6, WBG = 7, WBY = 8, MNT = 9;

    logic clk;
    logic rst;
    ddi_phase_sequencer_if bus();

    ddi_phase_sequencer #(.SYNC_RR_INIT(1'b0), .MAX_SYNC_RUN(MAX_RUN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus intent for the next edge
    bit e_in, w_in, m_in, r_in, noise_en;

    // model: state, cycles spent in it, latched requests, arbitration memory
    int m_st, m_age, m_run;
    bit m_pe, m_pw, m_rr, m_next_p2, m_ae, m_aw, m_valid;

    // last observed DUT outputs
    logic [3:0] obs_st;
    logic obs_ae, obs_aw, obs_pe, obs_pw, obs_ma;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dwell(input int s);
        case (s)
            AR:       return 1;
            P1G, P2G: return 30;
            EBG, WBG: return 12;
            MNT:      return 5;
            default:  return 3;
        endcase
    endfunction

    function automatic int after_phase(input int s);
        case (s)
            P1G: return P1Y;
            P2G: return P2Y;
            EBG: return EBY;
            WBG: return WBY;
            default: return AR;
        endcase
    endfunction

    function automatic bit is_green(input int s);
        return (s == P1G) || (s == P2G) || (s == EBG) || (s == WBG);
    endfunction

    task automatic model_advance(input bit done);
        int nst;
        bit fresh;
        if (r_in) begin
            m_st = AR; m_age = 0; m_pe = 0; m_pw = 0; m_rr = 0;
            m_next_p2 = 0; m_run = 0; m_ae = 0; m_aw = 0; m_valid = 1;
            return;
        end
        nst = m_st;
        fresh = (m_age == 0);
        if (m_st == MNT) begin
            nst = m_in ? MNT : AR;
        end else if (done && !fresh) begin
            if (m_st != AR && m_st < MNT) begin
                nst = after_phase(m_st);
            end else if (m_st != AR) begin
                nst = AR;
            end else if (m_in) begin
                nst = MNT;
            end else if ((m_pe || m_pw) && !(FAIR && m_run == MAX_RUN)) begin
                nst = (m_pe && (!m_pw || !m_rr)) ? EBG : WBG;
            end else begin
                nst = m_next_p2 ? P2G : P1G;
            end
        end
        m_ae = (nst != m_st) && (nst == EBG);
        m_aw = (nst != m_st) && (nst == WBG);
        if (m_ae) m_rr = 1;
        if (m_aw) m_rr = 0;
        if (m_ae || m_aw) m_run = (m_run < MAX_RUN) ? m_run + 1 : m_run;
        if (nst != m_st && (nst == P1G || nst == P2G)) begin
            m_next_p2 = !m_next_p2;
            m_run = 0;
        end
        m_pe = e_in || (m_pe && !m_ae);
        m_pw = w_in || (m_pw && !m_aw);
        m_age = (nst != m_st) ? 0 : m_age + 1;
        m_st = nst;
    endtask

    // One cycle: observe and compare, then drive the next edge and advance the model.
    task automatic step();
        bit done;
        @(negedge clk);
        obs_st = bus.current_state;
        obs_ae = bus.east_sync_ack;
        obs_aw = bus.west_sync_ack;
        obs_pe = bus.east_pending;
        obs_pw = bus.west_pending;
        obs_ma = bus.maint_active;
        if (m_valid) begin
            chk("state",    32'(obs_st), 32'(m_st));
            chk("east_ack", 32'(obs_ae), 32'(m_ae));
            chk("west_ack", 32'(obs_aw), 32'(m_aw));
            chk("east_pnd", 32'(obs_pe), 32'(m_pe));
            chk("west_pnd", 32'(obs_pw), 32'(m_pw));
            chk("maint",    32'(obs_ma), 32'(m_st == MNT));
        end
        done = (m_age + 1 >= dwell(m_st)) || (noise_en && ($urandom % 16 == 0));
        bus.timing_done   = done;
        bus.east_sync_req = e_in;
        bus.west_sync_req = w_in;
        bus.maint_req     = m_in;
        rst               = r_in;
        model_advance(done);
    endtask

    task automatic do_reset();
        r_in = 1; step(); step(); r_in = 0;
    endtask

    int seg_st[8];
    int seg_len[8];
    int nseg;
    int greens[6];
    int ng;
    int prev;
    int acks_seen;

    initial begin
        rst = 1'b1;
        bus.timing_done = 0; bus.east_sync_req = 0; bus.west_sync_req = 0; bus.maint_req = 0;
        e_in = 0; w_in = 0; m_in = 0; r_in = 0; noise_en = 0; m_valid = 0;

        // 1: free-running normal cycle
        do_reset();
        nseg = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (i == 0) begin
                chk("rst_state", 32'(obs_st), 32'(AR));
                chk("rst_pend",  32'({obs_pe, obs_pw}), 32'(0));
                chk("rst_ack",   32'({obs_ae, obs_aw, obs_ma}), 32'(0));
            end
            if (nseg == 0 || 32'(obs_st) != seg_st[nseg-1]) begin
                if (nseg < 8) begin
                    seg_st[nseg] = 32'(obs_st); seg_len[nseg] = 1; nseg++;
                end
            end else begin
                seg_len[nseg-1]++;
            end
        end
        chk("seq0_st", seg_st[0], AR);  chk("seq0_len", seg_len[0], 2);
        chk("seq1_st", seg_st[1], P1G); chk("seq1_len", seg_len[1], 30);
        chk("seq2_st", seg_st[2], P1Y); chk("seq2_len", seg_len[2], 3);
        chk("seq3_st", seg_st[3], AR);  chk("seq3_len", seg_len[3], 2);
        chk("seq4_st", seg_st[4], P2G); chk("seq4_len", seg_len[4], 30);

        // 2: east pulse during P1G is served at the next ALL_RED
        do_reset();
        for (int i = 0; i < 300 && obs_st != P1G; i++) step();
        chk("find_p1g", 32'(obs_st), 32'(P1G));
        e_in = 1; step(); e_in = 0; step();
        chk("east_latched", 32'(obs_pe), 32'(1));
        for (int i = 0; i < 300 && !obs_ae; i++) step();
        chk("east_ack_state", 32'(obs_st), 32'(EBG));
        chk("east_ack_pend",  32'(obs_pe), 32'(0));
        for (int i = 0; i < 300 && !(is_green(obs_st) && obs_st != EBG); i++) step();
        chk("after_eb_green", 32'(obs_st), 32'(P2G));

        // 3: maintenance waits for ALL_RED, then holds regardless of the timer
        m_in = 1;
        for (int i = 0; i < 300 && (obs_st == P2G || obs_st == P2Y); i++) step();
        chk("maint_via_ar", 32'(obs_st), 32'(AR));
        for (int i = 0; i < 20 && obs_st != MNT; i++) step();
        chk("maint_enter", 32'(obs_st), 32'(MNT));
        for (int i = 0; i < 60; i++) step();
        chk("maint_held", 32'({obs_st, obs_ma}), 32'({4'(MNT), 1'b1}));
        m_in = 0; step(); step();
        chk("maint_exit", 32'(obs_st), 32'(AR));
        for (int i = 0; i < 20 && !is_green(obs_st); i++) step();
        chk("maint_then_p1g", 32'(obs_st), 32'(P1G));

        // 4: simultaneous E/W requests, then reset in WB yellow with both pending
        do_reset();
        for (int i = 0; i < 300 && obs_st != P1G; i++) step();
        e_in = 1; w_in = 1; step(); e_in = 0; w_in = 0;
        for (int i = 0; i < 300 && !obs_ae; i++) step();
        chk("both_first",  32'(obs_st), 32'(EBG));
        chk("both_w_wait", 32'(obs_pw), 32'(1));
        for (int i = 0; i < 300 && !obs_aw; i++) step();
        chk("both_second", 32'(obs_st), 32'(WBG));
        e_in = 1; w_in = 1; step(); e_in = 0; w_in = 0;
        for (int i = 0; i < 300 && obs_st != WBY; i++) step();
        chk("wby_pend", 32'({obs_st, obs_pe, obs_pw}), 32'({4'(WBY), 2'b11}));
        r_in = 1; step(); r_in = 0; step();
        chk("mid_rst", 32'({obs_st, obs_pe, obs_pw}), 32'(0));
        acks_seen = 0;
        for (int i = 0; i < 20 && !is_green(obs_st); i++) begin
            step();
            acks_seen += int'(obs_ae) + int'(obs_aw);
        end
        chk("mid_rst_green", 32'(obs_st), 32'(P1G));
        chk("mid_rst_noack", 32'(acks_seen), 32'(0));

        // 5: continuous east request; fairness bounds the sync run
        do_reset();
        e_in = 1; ng = 0; prev = -1;
        for (int i = 0; i < 1000 && ng < 6; i++) begin
            step();
            if (32'(obs_st) != prev && is_green(obs_st)) begin
                greens[ng] = 32'(obs_st); ng++;
            end
            prev = 32'(obs_st);
        end
        e_in = 0;
        chk("fair_count", 32'(ng), 32'(6));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_g%0d", i), 32'(greens[i] == EBG),
                32'(FAIR ? (i % 3 != 2) : 1));
        end

        // 6: randomized traffic with blanking noise and occasional resets
        noise_en = 1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            e_in = ($urandom % 40 == 0);
            w_in = ($urandom % 40 == 0);
            if ($urandom % 150 == 0) m_in = !m_in;
            r_in = ($urandom % 700 == 0);
            step();
        end
        r_in = 0; m_in = 0; e_in = 0; w_in = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
